// File: rtl/fetch_bundle_queue_pkg.sv
// Shared widths, entry layout and defaults for the fetch-to-decode bundle queue.
// Build option: FETCH_BUNDLE_QUEUE_BYPASS_EN (empty-queue pass-through).
`ifndef SIZE_PC
`define SIZE_PC 32
`endif
`ifndef INSTRUCTION_BUNDLE
`define INSTRUCTION_BUNDLE 128
`endif

package fetch_bundle_queue_pkg;

  localparam int unsigned SIZE_PC_W   = `SIZE_PC;
  localparam int unsigned BUNDLE_W    = `INSTRUCTION_BUNDLE;
  localparam int unsigned FETCH_WIDTH = 4;
  localparam int unsigned DEPTH_DEF   = 4;

  // Packed entry layout, LSB first.
  localparam int unsigned TGT_OFF   = 0;
  localparam int unsigned TGT_W     = FETCH_WIDTH * SIZE_PC_W;
  localparam int unsigned PRED_OFF  = TGT_OFF + TGT_W;
  localparam int unsigned BTB_OFF   = PRED_OFF + FETCH_WIDTH;
  localparam int unsigned RAS_OFF   = BTB_OFF + FETCH_WIDTH;
  localparam int unsigned INSTR_OFF = RAS_OFF + SIZE_PC_W;
  localparam int unsigned PC_OFF    = INSTR_OFF + BUNDLE_W;
  localparam int unsigned ENTRY_W   = PC_OFF + SIZE_PC_W;

endpackage

// File: rtl/fetch_bundle_queue_ctrl.sv
// Pointer/occupancy control for the bundle queue: push/pop qualification, flush.
// Build option: FETCH_BUNDLE_QUEUE_BYPASS_EN.
module fetch_bundle_queue_ctrl
  import fetch_bundle_queue_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1),
  parameter int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             pushValid,
  input  logic             popReady,
  output logic [PTR_W-1:0] headPtr,
  output logic [PTR_W-1:0] tailPtr,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             push,
  output logic             bypassValid
);

  logic pop;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  // A full queue rejects pushes even when a pop frees a slot this cycle.
  assign pop = ~empty & popReady & ~flush;

`ifdef FETCH_BUNDLE_QUEUE_BYPASS_EN
  assign bypassValid = empty & pushValid & ~flush & reset;
  assign push        = pushValid & ~full & ~flush & ~(bypassValid & popReady);
`else
  assign bypassValid = 1'b0;
  assign push        = pushValid & ~full & ~flush;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      headPtr <= '0;
      tailPtr <= '0;
      count   <= '0;
    end else if (flush) begin
      headPtr <= '0;
      tailPtr <= '0;
      count   <= '0;
    end else begin
      if (pop)  headPtr <= headPtr + PTR_W'(1);
      if (push) tailPtr <= tailPtr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_bundle_queue.sv
// Decoupling FIFO of fetched bundles between FetchStage1 and decode.
// Build option: FETCH_BUNDLE_QUEUE_BYPASS_EN lets an empty queue pass input through.
module fetch_bundle_queue
  import fetch_bundle_queue_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush_i,
  input  logic                   valid_i,
  input  logic [SIZE_PC_W-1:0]   pc_i,
  input  logic [BUNDLE_W-1:0]    instructionBundle_i,
  input  logic [SIZE_PC_W-1:0]   addrRAS_CP_i,
  input  logic [FETCH_WIDTH-1:0] btbHit_i,
  input  logic [FETCH_WIDTH-1:0] prediction_i,
  input  logic [TGT_W-1:0]       targetAddr_i,
  input  logic                   ready_i,
  output logic                   stall_o,
  output logic                   valid_o,
  output logic [SIZE_PC_W-1:0]   pc_o,
  output logic [BUNDLE_W-1:0]    instructionBundle_o,
  output logic [SIZE_PC_W-1:0]   addrRAS_CP_o,
  output logic [FETCH_WIDTH-1:0] btbHit_o,
  output logic [FETCH_WIDTH-1:0] prediction_o,
  output logic [TGT_W-1:0]       targetAddr_o,
  output logic [CNT_W-1:0]       count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0]   headPtr;
  logic [PTR_W-1:0]   tailPtr;
  logic               full;
  logic               empty;
  logic               push;
  logic               bypassValid;
  logic [ENTRY_W-1:0] wrEntry;
  logic [ENTRY_W-1:0] rdEntry;
  logic [ENTRY_W-1:0] mem [DEPTH];

  fetch_bundle_queue_ctrl #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W),
    .PTR_W (PTR_W)
  ) u_ctrl (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush_i),
    .pushValid   (valid_i),
    .popReady    (ready_i),
    .headPtr     (headPtr),
    .tailPtr     (tailPtr),
    .count       (count_o),
    .full        (full),
    .empty       (empty),
    .push        (push),
    .bypassValid (bypassValid)
  );

  assign wrEntry = {pc_i, instructionBundle_i, addrRAS_CP_i, btbHit_i, prediction_i, targetAddr_i};

  // Storage needs no reset: the output mux zeroes the head fields while empty.
  always_ff @(posedge clk) begin
    if (push) mem[tailPtr] <= wrEntry;
  end

  always_comb begin
    rdEntry = '0;
    if (!empty)          rdEntry = mem[headPtr];
    else if (bypassValid) rdEntry = wrEntry;
  end

  assign stall_o             = full;
  assign valid_o             = ~empty | bypassValid;
  assign pc_o                = rdEntry[PC_OFF    +: SIZE_PC_W];
  assign instructionBundle_o = rdEntry[INSTR_OFF +: BUNDLE_W];
  assign addrRAS_CP_o        = rdEntry[RAS_OFF   +: SIZE_PC_W];
  assign btbHit_o            = rdEntry[BTB_OFF   +: FETCH_WIDTH];
  assign prediction_o        = rdEntry[PRED_OFF  +: FETCH_WIDTH];
  assign targetAddr_o        = rdEntry[TGT_OFF   +: TGT_W];

endmodule

// File: tb/tb_fetch_bundle_queue.sv
// Directed bench for fetch_bundle_queue; bundle fields are derived from the PC.
module tb_fetch_bundle_queue;
  import fetch_bundle_queue_pkg::*;

  logic         clk = 1'b0;
  logic         reset;
  logic         flush_i;
  logic         valid_i;
  logic [31:0]  pc_i;
  logic [127:0] instructionBundle_i;
  logic [31:0]  addrRAS_CP_i;
  logic [3:0]   btbHit_i;
  logic [3:0]   prediction_i;
  logic [127:0] targetAddr_i;
  logic         ready_i;
  logic         stall_o;
  logic         valid_o;
  logic [31:0]  pc_o;
  logic [127:0] instructionBundle_o;
  logic [31:0]  addrRAS_CP_o;
  logic [3:0]   btbHit_o;
  logic [3:0]   prediction_o;
  logic [127:0] targetAddr_o;
  logic [2:0]   count_o;

  int checks = 0;
  int errors = 0;

  fetch_bundle_queue #(.DEPTH(4)) dut (
    .clk                 (clk),
    .reset               (reset),
    .flush_i             (flush_i),
    .valid_i             (valid_i),
    .pc_i                (pc_i),
    .instructionBundle_i (instructionBundle_i),
    .addrRAS_CP_i        (addrRAS_CP_i),
    .btbHit_i            (btbHit_i),
    .prediction_i        (prediction_i),
    .targetAddr_i        (targetAddr_i),
    .ready_i             (ready_i),
    .stall_o             (stall_o),
    .valid_o             (valid_o),
    .pc_o                (pc_o),
    .instructionBundle_o (instructionBundle_o),
    .addrRAS_CP_o        (addrRAS_CP_o),
    .btbHit_o            (btbHit_o),
    .prediction_o        (prediction_o),
    .targetAddr_o        (targetAddr_o),
    .count_o             (count_o)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] instrOf(input logic [31:0] pc);
    return {pc ^ 32'h3000_0003, pc ^ 32'h2000_0002, pc ^ 32'h1000_0001, pc ^ 32'hDEAD_0000};
  endfunction
  function automatic logic [31:0] rasOf(input logic [31:0] pc);
    return pc + 32'h44;
  endfunction
  function automatic logic [3:0] btbOf(input logic [31:0] pc);
    return pc[8:5] ^ 4'h5;
  endfunction
  function automatic logic [3:0] predOf(input logic [31:0] pc);
    return pc[8:5] ^ 4'hA;
  endfunction
  function automatic logic [127:0] tgtOf(input logic [31:0] pc);
    return {pc + 32'h300, pc + 32'h200, pc + 32'h100, pc + 32'h10};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkHead(input string tag, input logic [31:0] pc);
    chk({tag, ".valid"}, valid_o, 1'b1);
    chk({tag, ".pc"}, pc_o, pc);
    chk({tag, ".instr"}, instructionBundle_o, instrOf(pc));
    chk({tag, ".ras"}, addrRAS_CP_o, rasOf(pc));
    chk({tag, ".btb"}, btbHit_o, btbOf(pc));
    chk({tag, ".pred"}, prediction_o, predOf(pc));
    chk({tag, ".tgt"}, targetAddr_o, tgtOf(pc));
  endtask

  task automatic present(input logic v, input logic [31:0] pc);
    valid_i             = v;
    pc_i                = pc;
    instructionBundle_i = instrOf(pc);
    addrRAS_CP_i        = rasOf(pc);
    btbHit_i            = btbOf(pc);
    prediction_i        = predOf(pc);
    targetAddr_i        = tgtOf(pc);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset   = 1'b0;
    flush_i = 1'b0;
    ready_i = 1'b0;
    present(1'b1, 32'h0);
    #3;
    step();
    step();
    chk("rst.valid", valid_o, 1'b0);
    chk("rst.stall", stall_o, 1'b0);
    chk("rst.count", count_o, 3'd0);
    chk("rst.pc", pc_o, 32'h0);
    chk("rst.tgt", targetAddr_o, 128'h0);

    reset = 1'b1;
    present(1'b0, 32'h0);
    #1;
    chk("rel.valid", valid_o, 1'b0);
    present(1'b1, 32'h0);
    step();
    checkHead("first", 32'h0);
    chk("first.count", count_o, 3'd1);

    // Back-pressure: fill to DEPTH, then present one more bundle.
    present(1'b1, 32'h20); step(); chk("bp.count2", count_o, 3'd2);
    present(1'b1, 32'h40); step(); chk("bp.count3", count_o, 3'd3);
    chk("bp.stall3", stall_o, 1'b0);
    present(1'b1, 32'h60); step();
    chk("bp.count4", count_o, 3'd4);
    chk("bp.stall4", stall_o, 1'b1);
    present(1'b1, 32'h80); step();
    chk("bp.held.count", count_o, 3'd4);
    chk("bp.held.stall", stall_o, 1'b1);
    checkHead("bp.held", 32'h0);
    ready_i = 1'b1;
    step();
    chk("bp.pop0.count", count_o, 3'd3);
    chk("bp.pop0.stall", stall_o, 1'b0);
    checkHead("bp.pop0", 32'h20);
    step();
    chk("bp.pop1.count", count_o, 3'd3);
    checkHead("bp.pop1", 32'h40);
    present(1'b0, 32'h0);
    step(); chk("bp.pop2.count", count_o, 3'd2); checkHead("bp.pop2", 32'h60);
    step(); chk("bp.pop3.count", count_o, 3'd1); checkHead("bp.pop3", 32'h80);
    step();
    chk("bp.empty.valid", valid_o, 1'b0);
    chk("bp.empty.count", count_o, 3'd0);

    // Steady state at occupancy 2.
    ready_i = 1'b0;
    present(1'b1, 32'hA0); step();
    present(1'b1, 32'hC0); step();
    chk("ss.fill.count", count_o, 3'd2);
    checkHead("ss.fill", 32'hA0);
    ready_i = 1'b1;
    present(1'b1, 32'hE0);  step(); chk("ss.c0", count_o, 3'd2); checkHead("ss.h0", 32'hC0);
    present(1'b1, 32'h180); step(); chk("ss.c1", count_o, 3'd2); checkHead("ss.h1", 32'hE0);
    present(1'b1, 32'h1A0); step(); chk("ss.c2", count_o, 3'd2); checkHead("ss.h2", 32'h180);
    present(1'b0, 32'h0);
    step(); chk("ss.d0", count_o, 3'd1); checkHead("ss.d0", 32'h1A0);
    step(); chk("ss.d1.valid", valid_o, 1'b0);

    // Flush with a simultaneous push and pop request.
    ready_i = 1'b0;
    present(1'b1, 32'h200); step();
    present(1'b1, 32'h220); step();
    present(1'b1, 32'h240); step();
    chk("fl.pre.count", count_o, 3'd3);
    flush_i = 1'b1;
    ready_i = 1'b1;
    present(1'b1, 32'h100);
    step();
    chk("fl.count", count_o, 3'd0);
    chk("fl.valid", valid_o, 1'b0);
    chk("fl.stall", stall_o, 1'b0);
    flush_i = 1'b0;
    ready_i = 1'b0;
    present(1'b0, 32'h0);
    step();
    chk("fl.after.count", count_o, 3'd0);
    chk("fl.after.valid", valid_o, 1'b0);
    present(1'b1, 32'h260);
    step();
    chk("fl.next.count", count_o, 3'd1);
    checkHead("fl.next", 32'h260);
    present(1'b0, 32'h0);
    ready_i = 1'b1;
    step();
    chk("fl.drain.valid", valid_o, 1'b0);

    // Wrap-around: one entry primed, then 11 push/pop pairs.
    ready_i = 1'b0;
    present(1'b1, 32'h0);
    step();
    chk("wr.prime.count", count_o, 3'd1);
    checkHead("wr.prime", 32'h0);
    ready_i = 1'b1;
    for (int unsigned k = 1; k < 12; k++) begin
      present(1'b1, 32'(k * 32'h20));
      step();
      chk("wr.count", count_o, 3'd1);
      checkHead("wr.head", 32'(k * 32'h20));
    end
    present(1'b0, 32'h0);
    step();
    chk("wr.end.valid", valid_o, 1'b0);
    chk("wr.end.count", count_o, 3'd0);

    // Empty queue, push and pop requested together.
    ready_i = 1'b1;
    present(1'b1, 32'h40);
    #1;
`ifdef FETCH_BUNDLE_QUEUE_BYPASS_EN
    checkHead("byp.same", 32'h40);
    chk("byp.same.count", count_o, 3'd0);
    step();
    chk("byp.next.count", count_o, 3'd0);
    present(1'b0, 32'h0);
    #1;
    chk("byp.next.valid", valid_o, 1'b0);
`else
    chk("nobyp.same.valid", valid_o, 1'b0);
    step();
    chk("nobyp.next.count", count_o, 3'd1);
    checkHead("nobyp.next", 32'h40);
    present(1'b0, 32'h0);
    step();
    chk("nobyp.drain.valid", valid_o, 1'b0);
    chk("nobyp.drain.count", count_o, 3'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_bundle_queue.md
Name: fetch_bundle_queue

Overview:
- Decoupling FIFO directly downstream of FetchStage1; sits between fetch and decode.
- Captures each fetched 4-instruction bundle together with its PC, RAS checkpoint and per-slot BTB/predictor results.
- Presents entries in order to decode and stalls FetchStage1 when no storage is left.
- Absorbs decode back-pressure and I-cache miss bubbles so the two sides run independently.

Parameters:
- DEPTH, 4, number of bundle entries; power of two, >= 2.
- CNT_W, $clog2(DEPTH+1), width of the occupancy count.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- flush_i  in  1  discard all entries; asserted on any ID/EX recovery, recoverFlag or exception.
- valid_i  in  1  FetchStage1 bundle valid (fs1Ready & ~miss).
- pc_i  in  `SIZE_PC  bundle PC.
- instructionBundle_i  in  `INSTRUCTION_BUNDLE  four instructions.
- addrRAS_CP_i  in  `SIZE_PC  RAS checkpoint address.
- btbHit_i  in  4  per-slot BTB hit; bit n = slot n.
- prediction_i  in  4  per-slot direction prediction.
- targetAddr_i  in  4*`SIZE_PC  per-slot target; slot n at [n*`SIZE_PC +: `SIZE_PC].
- ready_i  in  1  decode accepts the head entry this cycle.
- stall_o  out  1  to FetchStage1 stall_i; hold PC.
- valid_o  out  1  head entry valid.
- pc_o, instructionBundle_o, addrRAS_CP_o, btbHit_o, prediction_o, targetAddr_o  out  same widths as inputs  head entry fields.
- count_o  out  CNT_W  current occupancy.

Behaviour:
- Reset (reset=0, async):
  - Head and tail pointers = 0; count = 0.
  - valid_o = 0, stall_o = 0, count_o = 0.
  - Data outputs = 0.
  - Storage contents are don't-care.
- Push:
  - Accepted when valid_i & ~full.
  - Writes the entry at the tail on the posedge; tail increments modulo DEPTH.
  - When full, a push is rejected even if a pop occurs that cycle. FetchStage1 is stalled and re-presents the same bundle next cycle, so nothing is lost.
- Pop:
  - Occurs when valid_o & ready_i; head increments modulo DEPTH.
  - Head fields are driven from registered storage, so latency is 1 cycle minimum (push at edge N, visible at valid_o after edge N).
- Count:
  - Simultaneous accepted push and pop leaves count unchanged.
  - count = DEPTH means full; 0 means empty.
  - Pointers are log2(DEPTH) bits and wrap naturally.
- stall_o = full, purely from registered state; no combinational path from valid_i or ready_i.
- valid_o = ~empty.
- Flush:
  - On the posedge with flush_i=1, head, tail and count go to 0. Any push or pop in that cycle is ignored.
  - valid_o = 0 and stall_o = 0 in the following cycle.
  - flush_i has priority over everything except reset.
- Reset mid-operation: all state clears immediately (async); outputs are as at reset.
- Ordering: strict FIFO; per-slot fields of an entry are never split or reordered.

Optional Feature:
- Macro: FETCH_BUNDLE_QUEUE_BYPASS_EN.
- Defined:
  - When empty and valid_i=1, the output mux drives the input fields directly: valid_o=1 in the same cycle.
  - If ready_i=1 in that cycle the bundle is consumed without being written; count and pointers are unchanged.
  - If ready_i=0 it is written normally.
  - Flush suppresses the bypass valid (valid_o=0 while flush_i=1).
- Undefined: no bypass; minimum latency 1 cycle.

Decomposition:
- Shared package holds:
  - the bundle-entry field widths (`SIZE_PC, `INSTRUCTION_BUNDLE, FETCH_WIDTH=4);
  - the packed entry layout offsets;
  - the DEPTH default.
- One natural sub-module, fetch_bundle_queue_ctrl: head/tail/count, full/empty, push/pop qualification, flush.
- The top level holds the entry storage array and the output mux.

Test Plan:
- Reset asserted low with valid_i=1 -> valid_o=0, stall_o=0, count_o=0. After release, the first bundle PC 0x0 appears with valid_o=1 one cycle later.
- Back-pressure:
  - Stimulus: ready_i=0; push PCs 0x00, 0x20, 0x40, 0x60; present 0x80.
  - Response: stall_o=1 and count_o=4 after the 4th push; 0x80 is not written.
  - Then ready_i=1 -> pops 0x00, 0x20, 0x40, 0x60 in order. 0x80 is accepted once full deasserts.
- Steady state: count=2, valid_i=1 and ready_i=1 for 3 cycles -> count_o stays 2; output PCs follow FIFO order with btbHit/prediction/targetAddr slots intact.
- Flush: count=3 with flush_i=1 and a simultaneous push of PC 0x100 -> next cycle count_o=0, valid_o=0; 0x100 never appears.
- Wrap-around: 12 back-to-back push/pop pairs, PCs 0x0 to 0x160 step 0x20 -> output sequence identical to input across two pointer wraps.
- Bypass (FETCH_BUNDLE_QUEUE_BYPASS_EN):
  - Empty queue, valid_i=1, ready_i=1, pc_i=0x40 -> pc_o=0x40 and valid_o=1 in the same cycle; count_o remains 0.
  - Without the macro, the same stimulus gives valid_o=1 only in the next cycle.
